// File: rtl/key_debounce.sv
// Debouncer for 4 active-low push-buttons and 18 slide switches.
// Each input bit is synchronized, then qualified by a stable-count filter.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_in,
  input  logic [17:0] sw_in,
  output logic [3:0]  key_level,
  output logic [3:0]  key_press,
  output logic [3:0]  key_release,
  output logic [17:0] sw_out
);

  localparam int NCH = 22;
  localparam int CW  = $clog2(DB_CYCLES);

  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CONE = CW'(1);

  // Keys idle high (released), switches idle low.
  localparam logic [NCH-1:0] RST_VAL = {18'h0, 4'hF};

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] w_flip;
  logic [NCH-1:0] r_s1;
  logic [NCH-1:0] r_s2;
  logic [NCH-1:0] r_stable;
  logic [CW-1:0]  r_cnt [NCH];
  logic [3:0]     r_press;
  logic [3:0]     r_release;

  assign w_raw = {sw_in, key_in};

  // A channel flips when it has disagreed with stable for the full window.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < NCH; i++) begin
      w_flip[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CMAX);
    end
  end

  // Two-flop synchronizer on every raw input bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Per-channel stable-count filter; counter saturates at the flip point.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stable <= RST_VAL;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CONE;
        end
      end
    end
  end

  // Edge pulses aligned with the stable update; key stable=1 means released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= w_flip[3:0] & r_stable[3:0];
      r_release <= w_flip[3:0] & ~r_stable[3:0];
    end
  end

  assign key_level   = ~r_stable[3:0];
  assign sw_out      = r_stable[NCH-1:4];
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule
